// File: rtl/dmem_mmio_bridge.sv
// Data-memory port bridge: routes CPU loads/stores to a synchronous RAM or a small MMIO register window.
// Latency: one cycle from request to dm_ready for RAM and MMIO; TX stores stall while the TX holding register is full.
// Backpressure: dm_ready is the only completion signal; tx_valid/tx_ready is a valid-ready handshake with no byte lost or duplicated.
//
// Ports:
//   clk, reset                 - single clock, synchronous active-high reset
//   dm_addr/wdata/we/re        - request from the data-memory port (held until dm_ready)
//   dm_rdata/dm_ready          - response: one-cycle ready pulse, rdata held between responses
//   ram_addr/we/wdata/rdata    - word-addressed synchronous RAM (read data one cycle after address)
//   led, sw                    - LED register output, asynchronous switch inputs
//   tx_data/tx_valid/tx_ready  - byte stream to the serial transmitter
//   bus_err                    - sticky flag for unmapped or conflicting (re+we) accesses
module dmem_mmio_bridge #(
    parameter int unsigned RAM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  dm_addr,
    input  logic [31:0]                  dm_wdata,
    input  logic                         dm_we,
    input  logic                         dm_re,
    output logic [31:0]                  dm_rdata,
    output logic                         dm_ready,
    output logic [$clog2(RAM_WORDS)-1:0] ram_addr,
    output logic                         ram_we,
    output logic [31:0]                  ram_wdata,
    input  logic [31:0]                  ram_rdata,
    output logic [15:0]                  led,
    input  logic [15:0]                  sw,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         bus_err
);

    localparam int unsigned AW        = $clog2(RAM_WORDS);
    // 33 bits so RAM_WORDS*4 cannot overflow when the RAM spans the whole 4 GiB space
    localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RAM_WAIT = 2'd1,
        S_RESP     = 2'd2,
        S_TX_WAIT  = 2'd3
    } state_t;

    state_t      state_q,    state_d;
    logic        ram_rd_q,   ram_rd_d;    // RAM_WAIT is completing a read (vs a write)
    logic [31:0] rdata_q,    rdata_d;
    logic [15:0] led_q,      led_d;
    logic [7:0]  tx_data_q,  tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        bus_err_q,  bus_err_d;
    logic [31:0] cycle_q,    cycle_d;
    logic [15:0] sw_meta_q,  sw_sync_q;

    // ------------------------------------------------------------------
    // Address decode. Bits [1:0] never take part; RAM wins any overlap.
    // ------------------------------------------------------------------
    logic [31:0] addr_w;
    logic        ram_hit;
    logic        is_led, is_sw, is_cycle, is_tx;
    logic        req;

    assign addr_w   = {dm_addr[31:2], 2'b00};
    assign ram_hit  = {1'b0, dm_addr} < RAM_BYTES;
    assign is_led   = !ram_hit && (addr_w == MMIO_BASE);
    assign is_sw    = !ram_hit && (addr_w == MMIO_BASE + 32'h4);
    assign is_cycle = !ram_hit && (addr_w == MMIO_BASE + 32'h8);
    assign is_tx    = !ram_hit && (addr_w == MMIO_BASE + 32'hC);
    assign req      = dm_re || dm_we;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ram_rd_d   = ram_rd_q;
        rdata_d    = rdata_q;
        led_d      = led_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        bus_err_d  = bus_err_q;
        cycle_d    = cycle_q + 32'd1;

        // Transmitter handshake empties the holding register. A latch later
        // in this block overrides this only when the register was already
        // empty, so an accepted byte and a new byte never collide.
        if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (dm_re && dm_we) begin
                        bus_err_d = 1'b1;
                    end

                    if (ram_hit) begin
                        // Write strobe is issued combinationally this cycle;
                        // read data arrives from the RAM next cycle.
                        ram_rd_d = !dm_we;
                        state_d  = S_RAM_WAIT;
                    end else if (dm_we) begin
                        if (is_led) begin
                            led_d   = dm_wdata[15:0];
                            rdata_d = 32'h0;
                            state_d = S_RESP;
                        end else if (is_tx) begin
                            if (tx_valid_q) begin
                                // Holding register busy: wait without touching
                                // rdata so it keeps its last value until ready.
                                state_d = S_TX_WAIT;
                            end else begin
                                tx_data_d  = dm_wdata[7:0];
                                tx_valid_d = 1'b1;
                                rdata_d    = 32'h0;
                                state_d    = S_RESP;
                            end
                        end else begin
                            // SW and CYCLE are read-only: the write is dropped.
                            if (!is_sw && !is_cycle) begin
                                bus_err_d = 1'b1;
                            end
                            rdata_d = 32'h0;
                            state_d = S_RESP;
                        end
                    end else begin
                        if (is_led) begin
                            rdata_d = {16'h0, led_q};
                        end else if (is_sw) begin
                            rdata_d = {16'h0, sw_sync_q};
                        end else if (is_cycle) begin
                            rdata_d = cycle_q;
                        end else if (is_tx) begin
                            rdata_d = {31'h0, tx_valid_q};
                        end else begin
                            rdata_d   = 32'h0;
                            bus_err_d = 1'b1;
                        end
                        state_d = S_RESP;
                    end
                end
            end

            S_RAM_WAIT: begin
                // Capture what is presented this cycle so it holds afterwards.
                rdata_d = ram_rd_q ? ram_rdata : 32'h0;
                state_d = S_IDLE;
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            S_TX_WAIT: begin
                // Store data is held stable by the requester, so the byte is
                // taken straight from dm_wdata once the register has emptied.
                if (!tx_valid_q) begin
                    tx_data_d  = dm_wdata[7:0];
                    tx_valid_d = 1'b1;
                    rdata_d    = 32'h0;
                    state_d    = S_RESP;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ram_rd_q   <= 1'b0;
            rdata_q    <= 32'h0;
            led_q      <= 16'h0;
            tx_data_q  <= 8'h0;
            tx_valid_q <= 1'b0;
            bus_err_q  <= 1'b0;
            cycle_q    <= 32'h0;
            sw_meta_q  <= 16'h0;
            sw_sync_q  <= 16'h0;
        end else begin
            state_q    <= state_d;
            ram_rd_q   <= ram_rd_d;
            rdata_q    <= rdata_d;
            led_q      <= led_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            bus_err_q  <= bus_err_d;
            cycle_q    <= cycle_d;
            sw_meta_q  <= sw;
            sw_sync_q  <= sw_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Reset gates the completion pulse and the write strobe so an
    // abandoned transaction never completes or writes during the reset cycle.
    // ------------------------------------------------------------------
    assign ram_addr  = dm_addr[AW+1:2];
    assign ram_wdata = dm_wdata;
    assign ram_we    = !reset && (state_q == S_IDLE) && dm_we && ram_hit;

    assign dm_ready  = !reset && ((state_q == S_RAM_WAIT) || (state_q == S_RESP));
    assign dm_rdata  = (!reset && (state_q == S_RAM_WAIT))
                     ? (ram_rd_q ? ram_rdata : 32'h0)
                     : rdata_q;

    assign led       = led_q;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Self-checking bench for dmem_mmio_bridge: directed scenarios plus a randomized mix against a reference model.
// Latency: not applicable (testbench).
// Backpressure: drives tx_ready either from a script or randomly each cycle.
module tb_dmem_mmio_bridge;

    localparam int unsigned RAM_WORDS = 256;
    localparam int unsigned AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   dm_addr, dm_wdata, dm_rdata;
    logic          dm_we, dm_re, dm_ready;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic [15:0]   led, sw;
    logic [7:0]    tx_data;
    logic          tx_valid, tx_ready, bus_err;

    dmem_mmio_bridge #(.RAM_WORDS(RAM_WORDS), .MMIO_BASE(MMIO_BASE)) dut (
        .clk(clk), .reset(reset),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_re(dm_re),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .led(led), .sw(sw),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // ---------------- environment: synchronous RAM ----------------
    logic [31:0] mem [RAM_WORDS];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // ---------------- monitors ----------------
    int          we_cnt = 0;
    logic [AW-1:0] we_addr = '0;
    always @(posedge clk) begin
        if (ram_we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= ram_addr;
        end
    end

    logic [7:0] got_tx [$];
    always @(posedge clk) begin
        if (!reset && tx_valid && tx_ready) got_tx.push_back(tx_data);
    end

    // Reference cycle count: zero after a reset edge, +1 every other edge.
    logic [31:0] ref_cyc = 32'h0;
    always @(posedge clk) ref_cyc <= reset ? 32'h0 : ref_cyc + 32'd1;

    // tx_ready source: scripted or random per cycle
    logic dir_rdy = 1'b0;
    logic rnd_rdy = 1'b0;
    logic rand_tx = 1'b0;
    always @(negedge clk) rnd_rdy <= 1'($urandom_range(0, 1));
    assign tx_ready = rand_tx ? rnd_rdy : dir_rdy;

    // ---------------- reference model state ----------------
    logic [31:0] ref_mem [16];
    logic [15:0] ref_led = 16'h0;
    logic [7:0]  exp_tx [$];

    // One request/response. exp_lat < 0 skips the exact latency check.
    task automatic do_req(input string tag, input logic we, input logic re,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic use_cyc,
                          input int exp_lat, input int exp_we);
        int lat;
        int we0;
        logic [31:0] exp;
        logic [31:0] rd;
        @(negedge clk);
        dm_addr  = addr;
        dm_wdata = wd;
        dm_we    = we;
        dm_re    = re;
        we0      = we_cnt;
        exp      = use_cyc ? ref_cyc : exp_rd;
        lat      = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!dm_ready && lat < 200);
        chk({tag, "_ready"}, 32'(dm_ready), 32'd1);
        rd = dm_rdata;
        chk({tag, "_rdata"}, rd, exp);
        if (exp_lat >= 0) chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        dm_we = 1'b0;
        dm_re = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 32'(dm_ready), 32'd0);
        chk({tag, "_hold"}, dm_rdata, exp);
        chk({tag, "_ramwe_cnt"}, 32'(we_cnt - we0), 32'(exp_we));
        if (exp_we != 0) chk({tag, "_ramwe_addr"}, 32'(we_addr), 32'(addr[AW+1:2]));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"},   32'(dm_ready), 32'd0);
        chk({tag, "_rdata"},   dm_rdata,      32'd0);
        chk({tag, "_led"},     32'(led),      32'd0);
        chk({tag, "_txdata"},  32'(tx_data),  32'd0);
        chk({tag, "_txvalid"}, 32'(tx_valid), 32'd0);
        chk({tag, "_buserr"},  32'(bus_err),  32'd0);
        chk({tag, "_ramwe"},   32'(ram_we),   32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        logic [15:0] swv;
        int          w;
        int          op;
        int          tx_before;

        reset = 1'b1; dm_addr = 32'h0; dm_wdata = 32'h0; dm_we = 1'b0; dm_re = 1'b0; sw = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk) reset = 1'b0;

        // RAM write then read at byte 0x10 (word 4)
        do_req("ram_wr10", 1, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1, 1);
        do_req("ram_rd10", 0, 1, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1, 0);

        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            do_req("ram_fill", 1, 0, 32'(i * 4), ref_mem[i], 32'h0, 0, 1, 1);
        end
        // Highest RAM word is still RAM
        do_req("ram_wr_top", 1, 0, RAM_WORDS * 4 - 4, 32'hCAFE_F00D, 32'h0, 0, 1, 1);
        do_req("ram_rd_top", 0, 1, RAM_WORDS * 4 - 2, 32'h0, 32'hCAFE_F00D, 0, 1, 0);
        do_req("ram_rd_w3", 0, 1, 32'hF, 32'h0, ref_mem[3], 0, 1, 0);

        // LED register
        do_req("led_wr", 1, 0, MMIO_BASE, 32'h1234ABCD, 32'h0, 0, 1, 0);
        ref_led = 16'hABCD;
        chk("led_out", 32'(led), 32'h0000ABCD);
        do_req("led_rd", 0, 1, MMIO_BASE, 32'h0, 32'h0000ABCD, 0, 1, 0);

        // Switches: first read still sees the old synchronized value
        sw = 16'h00F0;
        do_req("sw_rd_early", 0, 1, MMIO_BASE + 32'h4, 32'h0, 32'h0, 0, 1, 0);
        do_req("sw_rd", 0, 1, MMIO_BASE + 32'h4, 32'h0, 32'h000000F0, 0, 1, 0);

        do_req("cyc_rd0", 0, 1, MMIO_BASE + 32'h8, 32'h0, 32'h0, 1, 1, 0);
        repeat (7) @(posedge clk);
        do_req("cyc_rd1", 0, 1, MMIO_BASE + 32'h8, 32'h0, 32'h0, 1, 1, 0);
        do_req("tx_stat0", 0, 1, MMIO_BASE + 32'hC, 32'h0, 32'h0, 0, 1, 0);

        // Two TX bytes with the transmitter stalled for 5 cycles
        dir_rdy = 1'b0;
        do_req("tx_41", 1, 0, MMIO_BASE + 32'hC, 32'h41, 32'h0, 0, 1, 0);
        chk("tx_41_valid", 32'(tx_valid), 32'd1);
        chk("tx_41_data", 32'(tx_data), 32'h41);
        do_req("tx_stat1", 0, 1, MMIO_BASE + 32'hC, 32'h0, 32'h1, 0, 1, 0);
        fork
            do_req("tx_42", 1, 0, MMIO_BASE + 32'hC, 32'h42, 32'h0, 0, 7, 0);
            begin
                repeat (5) @(posedge clk);
                #1 dir_rdy = 1'b1;
            end
        join
        chk("tx_42_data", 32'(tx_data), 32'h42);
        chk("tx_42_valid", 32'(tx_valid), 32'd0);
        chk("tx_count", 32'(got_tx.size()), 32'd2);
        if (got_tx.size() == 2) begin
            chk("tx_byte0", 32'(got_tx[0]), 32'h41);
            chk("tx_byte1", 32'(got_tx[1]), 32'h42);
        end
        got_tx.delete();

        // Randomized mix
        rand_tx = 1'b1;
        for (int i = 0; i < 250; i++) begin
            op = $urandom_range(0, 6);
            d  = $urandom;
            case (op)
                0: begin
                    w = $urandom_range(0, 15);
                    do_req("r_ramwr", 1, 0, 32'(w * 4 + $urandom_range(0, 3)), d, 32'h0, 0, 1, 1);
                    ref_mem[w] = d;
                end
                1: begin
                    w = $urandom_range(0, 15);
                    do_req("r_ramrd", 0, 1, 32'(w * 4 + $urandom_range(0, 3)), 32'h0, ref_mem[w], 0, 1, 0);
                end
                2: begin
                    do_req("r_ledwr", 1, 0, MMIO_BASE + 32'($urandom_range(0, 3)), d, 32'h0, 0, 1, 0);
                    ref_led = d[15:0];
                    chk("r_led_out", 32'(led), 32'(ref_led));
                end
                3: do_req("r_ledrd", 0, 1, MMIO_BASE, 32'h0, {16'h0, ref_led}, 0, 1, 0);
                4: begin
                    swv = d[15:0];
                    sw  = swv;
                    repeat (2) @(posedge clk);
                    do_req("r_swrd", 0, 1, MMIO_BASE + 32'h4 + 32'($urandom_range(0, 3)), 32'h0, {16'h0, swv}, 0, 1, 0);
                end
                5: do_req("r_cycrd", 0, 1, MMIO_BASE + 32'h8, 32'h0, 32'h0, 1, 1, 0);
                default: begin
                    b = d[7:0];
                    exp_tx.push_back(b);
                    do_req("r_txwr", 1, 0, MMIO_BASE + 32'hC, {24'h0, b}, 32'h0, 0, -1, 0);
                end
            endcase
        end
        rand_tx = 1'b0;
        dir_rdy = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("r_tx_count", 32'(got_tx.size()), 32'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++) begin
            chk("r_tx_byte", 32'(got_tx[i]), 32'(exp_tx[i]));
        end
        chk("r_buserr", 32'(bus_err), 32'd0);

        // re and we together: write wins, read ignored, error flagged
        d = 32'h5A5A_1234;
        do_req("rw_both", 1, 1, 32'hC, d, 32'h0, 0, 1, 1);
        ref_mem[3] = d;
        chk("rw_both_err", 32'(bus_err), 32'd1);
        do_req("rw_both_rd", 0, 1, 32'hC, 32'h0, d, 0, 1, 0);

        @(negedge clk) reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("rst_buserr", 32'(bus_err), 32'd0);
        @(negedge clk) reset = 1'b0;

        // Unmapped accesses
        do_req("unm_rd", 0, 1, MMIO_BASE + 32'h20, 32'h0, 32'h0, 0, 1, 0);
        chk("unm_err", 32'(bus_err), 32'd1);
        do_req("unm_ram_edge", 1, 0, RAM_WORDS * 4, 32'hFFFF_FFFF, 32'h0, 0, 1, 0);
        do_req("unm_wr10", 1, 0, MMIO_BASE + 32'h10, 32'h0000_7777, 32'h0, 0, 1, 0);
        chk("unm_led_kept", 32'(led), 32'h0);
        repeat (10) @(posedge clk);
        #1 chk("unm_err_sticky", 32'(bus_err), 32'd1);

        // Reset in the middle of a RAM read, with a pending TX byte
        do_req("pre_led", 1, 0, MMIO_BASE, 32'h5555, 32'h0, 0, 1, 0);
        dir_rdy = 1'b0;
        do_req("pre_tx", 1, 0, MMIO_BASE + 32'hC, 32'h77, 32'h0, 0, 1, 0);
        tx_before = got_tx.size();
        @(negedge clk);
        dm_addr = 32'h8; dm_re = 1'b1;
        @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("mid_rst_ready", 32'(dm_ready), 32'd0);
        chk("mid_rst_ramwe", 32'(ram_we), 32'd0);
        @(posedge clk);
        #1 check_reset_outputs("mid_rst");
        dm_re = 1'b0;
        dir_rdy = 1'b1;
        @(negedge clk) reset = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("mid_rst_tx_dropped", 32'(got_tx.size()), 32'(tx_before));
        do_req("post_cyc", 0, 1, MMIO_BASE + 32'h8, 32'h0, 32'h0, 1, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
